cla_m: RTL and testbench

- Registered carry-lookahead adder: adds two WIDTH-bit operands and a carry-in, and produces a (WIDTH+1)-bit sum whose MSB is the carry-out.
- Used as the reference-quality adder in the arithmetic block set.
- Default WIDTH=3, giving a 0..15 result range.
- Carries are computed by explicit generate/propagate lookahead logic, not a ripple chain. The result is registered on one clock.

---
 rtl/cla_m.sv | 50 +++++
 tb/tb_cla_m.sv | 100 ++++++++++
 2 files changed

// File: rtl/cla_m.sv
// Registered carry-lookahead adder: S <= A + B + Cin, with every carry
// flattened into a sum of products of generate/propagate terms and Cin.
module cla_m #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH:0]   S
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   c;

  assign g    = A & B;
  assign p    = A ^ B;
  assign c[0] = Cin;

  // c[k] = OR over j of (g[j] & p[k-1:j+1] all set), plus (Cin & p[k-1:0] all set).
  // Each propagate run is a constant mask, so no carry depends on a lower carry net.
  for (genvar k = 1; k <= WIDTH; k++) begin : g_carry
    localparam logic [WIDTH-1:0] CIN_MASK = WIDTH'((64'(1) << k) - 64'(1));
    logic [k:0] term;

    assign term[0] = Cin & (&(p | ~CIN_MASK));

    for (genvar j = 0; j < k; j++) begin : g_term
      localparam logic [WIDTH-1:0] RUN_MASK =
        WIDTH'((64'(1) << k) - (64'(1) << (j + 1)));
      assign term[j+1] = g[j] & (&(p | ~RUN_MASK));
    end

    assign c[k] = |term;
  end

  assign sum = p ^ c[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      S <= '0;
    end else begin
      S <= {c[WIDTH], sum};
    end
  end

endmodule

// File: tb/tb_cla_m.sv
// Directed and exhaustive checks of the registered carry-lookahead adder
// at its default 3-bit width.
module tb_cla_m;

  localparam int unsigned WIDTH = 3;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH:0]   s;

  int compared;
  int mismatched;

  cla_m #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .A   (a),
    .B   (b),
    .Cin (cin),
    .S   (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH:0] got,
                       input logic [WIDTH:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one operand set, clock it in, then check the registered sum.
  task automatic step(input string tag, input logic r, input int av,
                      input int bv, input int cv, input int exp);
    rst = r;
    a   = WIDTH'(av);
    b   = WIDTH'(bv);
    cin = 1'(cv);
    @(posedge clk);
    #1;
    check(tag, s, (WIDTH+1)'(exp));
  endtask

  initial begin
    int av;
    int bv;
    int cv;
    compared   = 0;
    mismatched = 0;
    rst = 1'b1;
    a   = '0;
    b   = '0;
    cin = 1'b0;

    step("reset_hold", 1'b1, 7, 7, 1, 0);
    step("reset_release", 1'b0, 7, 7, 1, 15);

    step("zero", 1'b0, 0, 0, 0, 0);
    step("ident_a5", 1'b0, 5, 0, 0, 5);
    step("cin_only", 1'b0, 0, 0, 1, 1);

    step("chain_7_0_1", 1'b0, 7, 0, 1, 8);
    step("max_no_cin", 1'b0, 7, 7, 0, 14);
    step("max_cin", 1'b0, 7, 7, 1, 15);

    step("mix_3_4_0", 1'b0, 3, 4, 0, 7);
    step("mix_3_5_1", 1'b0, 3, 5, 1, 9);
    step("mix_6_2_0", 1'b0, 6, 2, 0, 8);

    // Back-to-back sweep over every {Cin,B,A}.
    for (int n = 0; n < 128; n++) begin
      av = n & 7;
      bv = (n >> 3) & 7;
      cv = (n >> 6) & 1;
      step($sformatf("sweep_%0d", n), 1'b0, av, bv, cv, av + bv + cv);
    end

    // One-cycle reset dropped into a second sweep.
    for (int n = 0; n < 128; n++) begin
      av = (n * 5 + 3) & 7;
      bv = (n >> 3) & 7;
      cv = (n >> 6) & 1;
      if (n == 40) begin
        step("midreset", 1'b1, av, bv, cv, 0);
      end else begin
        step($sformatf("resume_%0d", n), 1'b0, av, bv, cv, av + bv + cv);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
